// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Purpose:
//   Round-robin arbiter for the shared internal CPU data bus. Four requesters
//   (register-file write port, ALU result, memory read, I/O) compete for the
//   bus. Grants are one-hot and registered. Every change of owner passes
//   through a one-cycle turnaround gap with no grant. An owner that has held
//   the bus for MAX_HOLD cycles is pre-empted, but only while another
//   requester is waiting.
//
// Handshake:
//   req[i] is a level request. It is held until grant[i] arrives and then for
//   as long as requester i wants the bus. Dropping req[i] releases the bus at
//   the next edge. A request that drops and is raised again between two edges
//   is never seen.
//
// Ports:
//   clk        - single clock; all state changes on the rising edge
//   reset      - asynchronous, active-low; clears all state immediately
//   req[N-1:0] - request vector, one bit per requester
//   grant      - one-hot grant, or all zero (registered)
//   busy       - registered copy of |grant
//   owner      - index of the current or most recent grantee (registered)
//   preempt    - one-cycle pulse in the gap cycle that follows a revoke caused
//                by the hold limit
//   dbg_state  - current FSM state (IDLE=0, OWN=1, GAP=2), for observation
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N        = 4,   // only 4 is supported; owner is 2 bits
    parameter int MAX_HOLD = 8    // 1..15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [1:0]   owner,
    output logic         preempt,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     last_q, last_d;
    logic [3:0]     hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           busy_q, busy_d;
    logic [1:0]     owner_q, owner_d;
    logic           preempt_q, preempt_d;

    // Round-robin pick: the first set request bit starting at last+1, wrapping
    // mod 4. The loop visits last itself last, so a lone requester that was
    // also the previous owner still wins.
    logic [1:0]     sel;
    logic [1:0]     cand;
    logic           found;

    always_comb begin
        sel   = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    logic at_max;
    logic others_waiting;

    assign at_max = (hold_cnt_q == 4'(MAX_HOLD));
    // In OWN, grant_q holds exactly the owner's bit, so masking it leaves the
    // requesters that are waiting.
    assign others_waiting = |(req & ~grant_q);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        preempt_d  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_GAP: begin
                grant_d = '0;
                if (|req) begin
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << sel;
                    owner_d    = sel;
                    last_d     = sel;
                    hold_cnt_d = 4'd1;
                    state_d    = ST_OWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!req[owner_q]) begin
                    // Release by the owner wins over a coincident pre-emption.
                    grant_d = '0;
                    state_d = ST_GAP;
                end else if (at_max && others_waiting) begin
                    grant_d   = '0;
                    preempt_d = 1'b1;
                    state_d   = ST_GAP;
                end else if (!at_max) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
                // Uncontended at the limit: hold_cnt stays saturated.
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = |grant_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 2'd3;     // requester 0 wins the first arbitration
            hold_cnt_q <= 4'd0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            owner_q    <= 2'd0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign preempt   = preempt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter (N=4, MAX_HOLD=8). Inputs change 1 time unit
// after each rising edge and outputs are sampled at that same point, well
// away from the next edge. Expected values are hand-derived from the arbiter
// behaviour: round-robin from last+1, a one-cycle gap between owners, and
// pre-emption after 8 held cycles while contended.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         busy;
    logic [1:0]   owner;
    logic         preempt;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_errors;

    bus_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .busy      (busy),
        .owner     (owner),
        .preempt   (preempt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic [3:0] exp_grant, input logic exp_pre);
        check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        check({tag, "_busy"}, 32'(busy), 32'(|exp_grant));
        check({tag, "_preempt"}, 32'(preempt), 32'(exp_pre));
    endtask

    // Reset pulse placed between edges; leaves the DUT in IDLE with last=3.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] exp_g;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        req      = 4'b1111;

        // Reset with all requests high: nothing granted.
        #12;
        check_bus("rst", 4'b0000, 1'b0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        check_bus("first", 4'b0001, 1'b0);
        check("first_owner", 32'(owner), 32'd0);
        check("first_state", 32'(dbg_state), 32'(S_OWN));

        // Round-robin: each owner holds 2 cycles, drops req once, gap, next.
        for (int i = 0; i < 4; i++) begin
            exp_g = 4'b0001 << i;
            if (i > 0) begin
                step();
                check_bus($sformatf("rr%0d_g1", i), exp_g, 1'b0);
                check($sformatf("rr%0d_owner", i), 32'(owner), 32'(i));
            end
            step();
            check_bus($sformatf("rr%0d_g2", i), exp_g, 1'b0);
            req = 4'b1111 & ~exp_g;
            step();
            check_bus($sformatf("rr%0d_gap", i), 4'b0000, 1'b0);
            check($sformatf("rr%0d_gapst", i), 32'(dbg_state), 32'(S_GAP));
            req = 4'b1111;
        end
        step();
        check_bus("rr_wrap", 4'b0001, 1'b0);

        // Full release: GAP then IDLE, owner remembers 0.
        req = 4'b0000;
        step();
        check_bus("rel_gap", 4'b0000, 1'b0);
        step();
        check("rel_idle", 32'(dbg_state), 32'(S_IDLE));
        check("rel_owner", 32'(owner), 32'd0);

        // Pre-emption with req=0011 after a fresh reset.
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < MAX_HOLD; c++) begin
            step();
            check_bus($sformatf("pe0_c%0d", c), 4'b0001, 1'b0);
        end
        step();
        check_bus("pe0_revoke", 4'b0000, 1'b1);
        for (int c = 0; c < MAX_HOLD; c++) begin
            step();
            check_bus($sformatf("pe1_c%0d", c), 4'b0010, 1'b0);
        end
        check("pe1_owner", 32'(owner), 32'd1);
        step();
        check_bus("pe1_revoke", 4'b0000, 1'b1);
        step();
        check_bus("pe_back0", 4'b0001, 1'b0);

        // Uncontended hold: only requester 2; owner 0 releases first.
        req = 4'b0100;
        step();
        check_bus("unc_gap", 4'b0000, 1'b0);
        step();
        check_bus("unc_grant", 4'b0100, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step();
            check_bus($sformatf("unc_c%0d", c), 4'b0100, 1'b0);
        end
        check("unc_owner", 32'(owner), 32'd2);

        // Async reset mid-grant: grant drops before the next edge.
        #2;
        reset = 1'b0;
        #1;
        check_bus("areset", 4'b0000, 1'b0);
        check("areset_owner", 32'(owner), 32'd0);
        check("areset_state", 32'(dbg_state), 32'(S_IDLE));
        reset = 1'b1;
        step();
        check_bus("areset_regrant", 4'b0100, 1'b0);
        check("areset_owner2", 32'(owner), 32'd2);

        // Simultaneous release and pre-emption condition on owner 1.
        do_reset();
        req = 4'b0010;
        step();
        check_bus("sim_grant", 4'b0010, 1'b0);
        for (int c = 0; c < 12; c++) begin
            step();
            check_bus($sformatf("sim_hold%0d", c), 4'b0010, 1'b0);
        end
        req = 4'b1000;
        step();
        check_bus("sim_gap", 4'b0000, 1'b0);
        check("sim_gapst", 32'(dbg_state), 32'(S_GAP));
        step();
        check_bus("sim_next", 4'b1000, 1'b0);
        check("sim_owner", 32'(owner), 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
